uart_transceiver: RTL and testbench

Full-duplex 8N1 UART that serialises and deserialises bytes for the debug unit. The debug unit consumes received bytes via `rx_ready`/`rx_data` and produces response bytes via `tx_write`/`tx_data`, paced by `tx_finished`. The RX and TX paths are independent and may operate simultaneously. All state is on `posedge clk`; the debug unit samples these outputs on the opposite edge.

---
 rtl/uart_pkg.sv | 26 ++
 rtl/uart_bit_timer.sv | 41 ++++
 rtl/uart_transceiver.sv | 230 +++++++++++++++++++++++
 tb/tb_uart_transceiver.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the debug-unit UART: FSM encodings, framing
// constants and the baud divisor computation.
package uart_pkg;

    typedef enum logic [1:0] {
        RX_IDLE  = 2'd0,
        RX_START = 2'd1,
        RX_DATA  = 2'd2,
        RX_STOP  = 2'd3
    } rx_state_t;

    typedef enum logic [1:0] {
        TX_IDLE  = 2'd0,
        TX_START = 2'd1,
        TX_DATA  = 2'd2,
        TX_STOP  = 2'd3
    } tx_state_t;

    localparam int SYNC_STAGES = 2;
    localparam int DATA_BITS   = 8;

    function automatic int calc_clks_per_bit(input int clk_hz, input int baud);
        return clk_hz / baud;
    endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// Bit-period down-counter: load restarts a full (or half) bit period and
// tick flags the last cycle of that period.
module uart_bit_timer
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic clk,
    input  logic n_reset,
    input  logic load,
    input  logic half,
    output logic tick
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] FULL_LOAD = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] HALF_LOAD = CNT_W'(CLKS_PER_BIT / 2 - 1);

    logic [CNT_W-1:0] count_reg;
    logic [CNT_W-1:0] count_next;

    always_comb begin
        count_next = count_reg;
        if (load) begin
            count_next = half ? HALF_LOAD : FULL_LOAD;
        end else if (count_reg != '0) begin
            count_next = count_reg - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!n_reset) begin
            count_reg <= '0;
        end else begin
            count_reg <= count_next;
        end
    end

    assign tick = (count_reg == '0);

endmodule

// File: rtl/uart_transceiver.sv
// Full-duplex 8N1 UART for the debug unit. RX and TX are fully independent
// state machines, each paced by its own bit timer.
module uart_transceiver
    import uart_pkg::*;
#(
    parameter int CLK_HZ = 1_600_000,
    parameter int BAUD   = 100_000
) (
    input  logic       clk,
    input  logic       n_reset,
    input  logic       rx,
    output logic       tx,
    output logic       rx_ready,
    output logic [7:0] rx_data,
    output logic       rx_frame_err,
    input  logic       tx_write,
    input  logic [7:0] tx_data,
    output logic       tx_finished,
    output logic       tx_busy
);

    localparam int CLKS_PER_BIT = calc_clks_per_bit(CLK_HZ, BAUD);

    generate
        if ((CLK_HZ % BAUD) != 0 || CLKS_PER_BIT < 4) begin : g_bad_baud
            $fatal(1, "uart_transceiver: CLK_HZ/BAUD must be an integer >= 4");
        end
    endgenerate

    // Two-stage synchronizer; resets to the idle line level
    logic [SYNC_STAGES-1:0] sync_reg;
    logic                   rx_s;

    generate
        for (genvar gi = 0; gi < SYNC_STAGES; gi++) begin : g_sync
            always_ff @(posedge clk) begin
                if (!n_reset) begin
                    sync_reg[gi] <= 1'b1;
                end else if (gi == 0) begin
                    sync_reg[gi] <= rx;
                end else begin
                    sync_reg[gi] <= sync_reg[(gi == 0) ? 0 : gi-1];
                end
            end
        end
    endgenerate

    assign rx_s = sync_reg[SYNC_STAGES-1];

    rx_state_t              rx_state_reg, rx_state_next;
    logic [DATA_BITS-1:0]   rx_shift_reg, rx_shift_next;
    logic [2:0]             rx_bit_reg, rx_bit_next;
    logic [DATA_BITS-1:0]   rx_data_reg, rx_data_next;
    logic                   rx_ready_reg, rx_ready_next;
    logic                   rx_err_reg, rx_err_next;
    logic                   rx_load, rx_half, rx_tick;

    tx_state_t              tx_state_reg, tx_state_next;
    logic [DATA_BITS-1:0]   tx_shift_reg, tx_shift_next;
    logic [2:0]             tx_bit_reg, tx_bit_next;
    logic                   tx_reg, tx_next;
    logic                   tx_busy_reg, tx_busy_next;
    logic                   tx_fin_reg, tx_fin_next;
    logic                   tx_load, tx_tick;

    uart_bit_timer #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx_timer (
        .clk     (clk),
        .n_reset (n_reset),
        .load    (rx_load),
        .half    (rx_half),
        .tick    (rx_tick)
    );

    uart_bit_timer #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_tx_timer (
        .clk     (clk),
        .n_reset (n_reset),
        .load    (tx_load),
        .half    (1'b0),
        .tick    (tx_tick)
    );

    // RX returns to idle in the middle of the stop bit so the next start
    // edge of a back-to-back frame is never missed.
    always_comb begin
        rx_state_next = rx_state_reg;
        rx_shift_next = rx_shift_reg;
        rx_bit_next   = rx_bit_reg;
        rx_data_next  = rx_data_reg;
        rx_ready_next = 1'b0;
        rx_err_next   = 1'b0;
        rx_load       = 1'b0;
        rx_half       = 1'b0;
        case (rx_state_reg)
            RX_IDLE: begin
                if (!rx_s) begin
                    rx_load       = 1'b1;
                    rx_half       = 1'b1;
                    rx_state_next = RX_START;
                end
            end
            RX_START: begin
                if (rx_tick) begin
                    if (rx_s) begin
                        rx_state_next = RX_IDLE;
                    end else begin
                        rx_load       = 1'b1;
                        rx_bit_next   = 3'd0;
                        rx_state_next = RX_DATA;
                    end
                end
            end
            RX_DATA: begin
                if (rx_tick) begin
                    rx_load       = 1'b1;
                    rx_shift_next = {rx_s, rx_shift_reg[DATA_BITS-1:1]};
                    if (rx_bit_reg == 3'(DATA_BITS - 1)) begin
                        rx_state_next = RX_STOP;
                    end else begin
                        rx_bit_next = rx_bit_reg + 3'd1;
                    end
                end
            end
            RX_STOP: begin
                if (rx_tick) begin
                    if (rx_s) begin
                        rx_data_next  = rx_shift_reg;
                        rx_ready_next = 1'b1;
                    end else begin
                        rx_err_next = 1'b1;
                    end
                    rx_state_next = RX_IDLE;
                end
            end
            default: rx_state_next = RX_IDLE;
        endcase
    end

    // tx_next is the line level for the coming bit, registered on the edge
    // where the state changes so every level lasts one full bit period.
    always_comb begin
        tx_state_next = tx_state_reg;
        tx_shift_next = tx_shift_reg;
        tx_bit_next   = tx_bit_reg;
        tx_next       = tx_reg;
        tx_busy_next  = tx_busy_reg;
        tx_fin_next   = 1'b0;
        tx_load       = 1'b0;
        case (tx_state_reg)
            TX_IDLE: begin
                tx_next = 1'b1;
                if (tx_write) begin
                    tx_shift_next = tx_data;
                    tx_busy_next  = 1'b1;
                    tx_next       = 1'b0;
                    tx_load       = 1'b1;
                    tx_state_next = TX_START;
                end
            end
            TX_START: begin
                if (tx_tick) begin
                    tx_load       = 1'b1;
                    tx_next       = tx_shift_reg[0];
                    tx_shift_next = {1'b0, tx_shift_reg[DATA_BITS-1:1]};
                    tx_bit_next   = 3'd0;
                    tx_state_next = TX_DATA;
                end
            end
            TX_DATA: begin
                if (tx_tick) begin
                    tx_load = 1'b1;
                    if (tx_bit_reg == 3'(DATA_BITS - 1)) begin
                        tx_next       = 1'b1;
                        tx_state_next = TX_STOP;
                    end else begin
                        tx_next       = tx_shift_reg[0];
                        tx_shift_next = {1'b0, tx_shift_reg[DATA_BITS-1:1]};
                        tx_bit_next   = tx_bit_reg + 3'd1;
                    end
                end
            end
            TX_STOP: begin
                if (tx_tick) begin
                    tx_next       = 1'b1;
                    tx_busy_next  = 1'b0;
                    tx_fin_next   = 1'b1;
                    tx_state_next = TX_IDLE;
                end
            end
            default: tx_state_next = TX_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!n_reset) begin
            rx_state_reg <= RX_IDLE;
            rx_shift_reg <= '0;
            rx_bit_reg   <= '0;
            rx_data_reg  <= '0;
            rx_ready_reg <= 1'b0;
            rx_err_reg   <= 1'b0;
            tx_state_reg <= TX_IDLE;
            tx_shift_reg <= '0;
            tx_bit_reg   <= '0;
            tx_reg       <= 1'b1;
            tx_busy_reg  <= 1'b0;
            tx_fin_reg   <= 1'b0;
        end else begin
            rx_state_reg <= rx_state_next;
            rx_shift_reg <= rx_shift_next;
            rx_bit_reg   <= rx_bit_next;
            rx_data_reg  <= rx_data_next;
            rx_ready_reg <= rx_ready_next;
            rx_err_reg   <= rx_err_next;
            tx_state_reg <= tx_state_next;
            tx_shift_reg <= tx_shift_next;
            tx_bit_reg   <= tx_bit_next;
            tx_reg       <= tx_next;
            tx_busy_reg  <= tx_busy_next;
            tx_fin_reg   <= tx_fin_next;
        end
    end

    assign tx           = tx_reg;
    assign tx_busy      = tx_busy_reg;
    assign tx_finished  = tx_fin_reg;
    assign rx_ready     = rx_ready_reg;
    assign rx_data      = rx_data_reg;
    assign rx_frame_err = rx_err_reg;

endmodule

// File: tb/tb_uart_transceiver.sv
// Bench for uart_transceiver: a frame-level model predicts tx/busy/finished
// every cycle and a receive scoreboard predicts rx pulses within a latency window.
module tb_uart_transceiver;

    localparam int CLK_HZ = 1_600_000;
    localparam int BAUD   = 100_000;
    localparam int CPB    = 16;
    localparam int L_RX   = 2 + CPB/2 + 9*CPB;

    logic       clk = 1'b0;
    logic       n_reset = 1'b0;
    logic       rx = 1'b1;
    logic       tx_write = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       tx, rx_ready, rx_frame_err, tx_finished, tx_busy;
    logic [7:0] rx_data;

    always #5 clk = ~clk;

    uart_transceiver #(.CLK_HZ(CLK_HZ), .BAUD(BAUD)) dut (
        .clk          (clk),
        .n_reset      (n_reset),
        .rx           (rx),
        .tx           (tx),
        .rx_ready     (rx_ready),
        .rx_data      (rx_data),
        .rx_frame_err (rx_frame_err),
        .tx_write     (tx_write),
        .tx_data      (tx_data),
        .tx_finished  (tx_finished),
        .tx_busy      (tx_busy)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    // transmit model state
    bit         m_valid = 1'b0;
    bit         m_rst_edge = 1'b0;
    bit         m_tx_active = 1'b0;
    bit         m_accept;
    int         m_tx_acc = 0;
    int         m_fin_edge = -1;
    logic [7:0] m_tx_byte = 8'h00;
    logic       m_exp_tx = 1'b1;
    logic       m_exp_busy = 1'b0;
    logic       m_exp_fin = 1'b0;
    logic [7:0] m_rx_data = 8'h00;

    typedef struct {
        bit         is_ready;
        logic [7:0] data;
        int         lo;
        int         hi;
    } rx_evt_t;

    rx_evt_t    rx_q[$];
    logic [7:0] rx_log[$];
    int         fin_count = 0;
    int         fin_edge_seen = 0;
    int         err_count = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h at edge %0d", name, got, exp, cyc);
        end
    endtask

    // Line level of an 8N1 frame at bit slot idx (0 = start, 9 = stop)
    function automatic logic frame_bit(input logic [7:0] b, input int idx);
        if (idx == 0) return 1'b0;
        if (idx <= 8) return b[idx-1];
        return 1'b1;
    endfunction

    // Model: a write is taken when no frame is in flight; a frame is 10 bit
    // slots from the accepting edge, finished is flagged on the edge after.
    initial begin
        forever begin
            @(posedge clk);
            cyc++;
            m_rst_edge = !n_reset;
            if (!n_reset) begin
                m_valid     = 1'b1;
                m_tx_active = 1'b0;
            end else begin
                m_accept = tx_write && !m_tx_active;
                if (m_tx_active && (cyc - m_tx_acc) == 10*CPB) begin
                    m_tx_active = 1'b0;
                    m_fin_edge  = cyc;
                end
                if (m_accept) begin
                    m_tx_active = 1'b1;
                    m_tx_acc    = cyc;
                    m_tx_byte   = tx_data;
                end
            end
            m_exp_busy = m_tx_active;
            m_exp_tx   = m_tx_active ? frame_bit(m_tx_byte, (cyc - m_tx_acc) / CPB) : 1'b1;
            m_exp_fin  = n_reset && (m_fin_edge == cyc);
        end
    end

    // Compare process
    initial begin
        forever begin
            @(negedge clk);
            if (m_valid) begin
                if (m_rst_edge) begin
                    m_rx_data = 8'h00;
                    rx_q.delete();
                end
                if (tx_finished) begin
                    fin_count++;
                    fin_edge_seen = cyc;
                end
                if (rx_frame_err) err_count++;
                if (rx_ready || rx_frame_err) begin
                    checks++;
                    if (rx_ready) rx_log.push_back(rx_data);
                    if (rx_q.size() == 0) begin
                        errors++;
                        $display("FAIL rx_event unexpected ready=%0b err=%0b at edge %0d", rx_ready, rx_frame_err, cyc);
                    end else if (rx_q[0].is_ready != rx_ready || rx_q[0].is_ready == rx_frame_err
                                 || cyc < rx_q[0].lo || cyc > rx_q[0].hi) begin
                        errors++;
                        $display("FAIL rx_event ready=%0b err=%0b at edge %0d, expected ready=%0b in edges %0d..%0d",
                                 rx_ready, rx_frame_err, cyc, rx_q[0].is_ready, rx_q[0].lo, rx_q[0].hi);
                        void'(rx_q.pop_front());
                    end else begin
                        if (rx_ready) m_rx_data = rx_q[0].data;
                        void'(rx_q.pop_front());
                    end
                end else if (rx_q.size() != 0 && cyc > rx_q[0].hi) begin
                    checks++;
                    errors++;
                    $display("FAIL rx_timeout no pulse by edge %0d, expected ready=%0b", rx_q[0].hi, rx_q[0].is_ready);
                    void'(rx_q.pop_front());
                end
                check("tx", tx, m_exp_tx);
                check("tx_busy", tx_busy, m_exp_busy);
                check("tx_finished", tx_finished, m_exp_fin);
                check("rx_data", rx_data, m_rx_data);
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic tx_send(input logic [7:0] b);
        tx_data  = b;
        tx_write = 1'b1;
        step(1);
        tx_write = 1'b0;
    endtask

    // Drive one frame; pct is line rate in percent of nominal
    task automatic rx_frame(input logic [7:0] b, input logic stop_bit, input int pct);
        logic [9:0] bits;
        int         len;
        int         s;
        rx_evt_t    e;
        bits = {stop_bit, b, 1'b0};
        len  = (10*CPB*100 + pct - 1) / pct;
        s    = cyc;
        e.is_ready = stop_bit;
        e.data     = b;
        e.lo       = s + L_RX - 1;
        e.hi       = s + L_RX + 1;
        rx_q.push_back(e);
        for (int c = 0; c < len; c++) begin
            rx = bits[(c*pct) / (CPB*100)];
            step(1);
        end
        rx = 1'b1;
    endtask

    logic exp_a5 [10] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};

    initial begin
        int w;
        int a;
        int n;
        n_reset = 1'b0;
        step(3);
        n_reset = 1'b1;
        step(1);
        check("reset_tx", tx, 1);
        check("reset_rx_ready", rx_ready, 0);
        check("reset_rx_data", rx_data, 0);
        check("reset_frame_err", rx_frame_err, 0);
        check("reset_finished", tx_finished, 0);
        check("reset_busy", tx_busy, 0);

        // single byte 0xA5, mid-bit samples against the literal line sequence
        fin_count = 0;
        w = cyc;
        tx_send(8'hA5);
        a = cyc;
        for (int b = 0; b < 10; b++) begin
            while (cyc < a + CPB*b + CPB/2) step(1);
            check("tx_a5_bit", tx, exp_a5[b]);
        end
        while (cyc < a + 10*CPB + 10) step(1);
        check("tx_a5_fin_count", fin_count, 1);
        check("tx_a5_fin_cycle", fin_edge_seen - w, 161);

        // busy write ignored, then a write in the finished cycle
        fin_count = 0;
        tx_send(8'h01);
        step(50);
        tx_send(8'hFF);
        n = 0;
        while (!tx_finished && n < 400) begin
            step(1);
            n++;
        end
        check("b2b_fin_seen", tx_finished, 1);
        tx_send(8'h80);
        check("b2b_start_bit", tx, 0);
        check("b2b_busy", tx_busy, 1);
        step(10*CPB + 20);
        check("b2b_fin_count", fin_count, 2);

        // reset while shifting data bits
        fin_count = 0;
        tx_send(8'h0F);
        step(40);
        n_reset = 1'b0;
        step(1);
        check("rst_mid_tx", tx, 1);
        check("rst_mid_busy", tx_busy, 0);
        step(2);
        n_reset = 1'b1;
        step(200);
        check("rst_no_fin", fin_count, 0);

        // back-to-back receive
        rx_frame(8'h3C, 1'b1, 100);
        rx_frame(8'hC3, 1'b1, 100);
        step(20);
        check("rx_count2", rx_log.size(), 2);
        check("rx_first", rx_log[0], 8'h3C);
        check("rx_second", rx_log[1], 8'hC3);
        check("rx_data_c3", rx_data, 8'hC3);

        // 8-cycle glitch, then a framing error
        rx = 1'b0;
        step(8);
        rx = 1'b1;
        step(200);
        check("glitch_no_ready", rx_log.size(), 2);
        check("glitch_no_err", err_count, 0);
        rx_frame(8'h55, 1'b0, 100);
        step(200);
        check("ferr_count", err_count, 1);
        check("ferr_no_ready", rx_log.size(), 2);
        check("ferr_data_kept", rx_data, 8'hC3);

        // full duplex at +3% then -3% receive rate
        fin_count = 0;
        fork
            tx_send(8'h5A);
            rx_frame(8'h12, 1'b1, 103);
        join
        step(200);
        check("dup_fast_rx", rx_data, 8'h12);
        check("dup_fast_fin", fin_count, 1);
        fork
            tx_send(8'h5A);
            rx_frame(8'h12, 1'b1, 97);
        join
        step(200);
        check("dup_slow_rx_count", rx_log.size(), 4);
        check("dup_slow_rx", rx_log[3], 8'h12);
        check("dup_slow_fin", fin_count, 2);
        check("rx_q_drained", rx_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1_000_000;
        errors++;
        $display("FAIL watchdog timeout at edge %0d", cyc);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
